elevador_call_arbiter: RTL

- Upstream request stage for the 3-floor elevator controller.
- Turns raw, bouncing hall/car call buttons into clean, latched floor requests and drives the controller's p1/p2/p3 request inputs.
- Presents exactly one one-hot request at a time; the controller only acts on a single active request line.
- Holds each request until the car is parked at that floor; drives per-floor call lamps.

---
 rtl/elevador_call_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/elevador_call_arbiter.sv
// Upstream request stage for the 3-floor elevator: debounces call buttons, latches
// pending calls and presents one one-hot request at a time to the controller.
module elevador_call_arbiter #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter int PRESENT_MAX     = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn_raw,
    input  logic [2:0] floor_sns,
    input  logic       moving,
    output logic [2:0] req_p,
    output logic [2:0] lamp,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int PCNT_W = $clog2(PRESENT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESENT     = 2'd1,
        ST_WAIT_ARRIVE = 2'd2
    } state_t;

    logic [2:0]       r_sync1, r_sync2, r_deb, r_deb_d;
    logic [CNT_W-1:0] r_cnt [3];
    logic [2:0]       r_pend, r_lamp, r_req_p;
    state_t           r_state;
    logic [1:0]       r_target, r_rr;
    logic [PCNT_W-1:0] r_pcnt;
    logic             r_busy;

    logic [2:0] w_park, w_rise, w_eligible;
    logic [1:0] w_idx0, w_idx1, w_idx2, w_pick;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Counter only runs while the synced input disagrees with the accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_park     = floor_sns & {3{~moving}};
    assign w_rise     = r_deb & ~r_deb_d;
    assign w_eligible = r_pend & ~floor_sns;

    always_comb begin
        w_idx0 = r_rr;
        w_idx1 = inc3(r_rr);
        w_idx2 = inc3(w_idx1);
        if (w_eligible[w_idx0])      w_pick = w_idx0;
        else if (w_eligible[w_idx1]) w_pick = w_idx1;
        else                         w_pick = w_idx2;
    end

    // A parked car clears its floor's call, and that clear beats a same-cycle press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
            r_lamp <= '0;
        end else begin
            r_pend <= (r_pend | w_rise) & ~w_park;
            r_lamp <= r_pend;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_rr     <= '0;
            r_pcnt   <= '0;
            r_req_p  <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!moving && w_eligible != 3'b000) begin
                        r_state  <= ST_PRESENT;
                        r_target <= w_pick;
                        r_pcnt   <= '0;
                        r_req_p  <= 3'b001 << w_pick;
                        r_busy   <= 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (moving) begin
                        r_state <= ST_WAIT_ARRIVE;
                        r_req_p <= '0;
                    end else if (!r_pend[r_target] || w_park[r_target]) begin
                        r_state <= ST_IDLE;
                        r_req_p <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_pcnt == PCNT_W'(PRESENT_MAX - 1)) begin
                        // Give up on this floor for now; the call stays pending.
                        r_state <= ST_IDLE;
                        r_req_p <= '0;
                        r_busy  <= 1'b0;
                        r_rr    <= inc3(r_target);
                    end else begin
                        r_pcnt <= r_pcnt + PCNT_W'(1);
                    end
                end
                ST_WAIT_ARRIVE: begin
                    if (!moving && floor_sns != 3'b000) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        if (floor_sns[r_target]) r_rr <= inc3(r_target);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req_p <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req_p     = r_req_p;
    assign lamp      = r_lamp;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule
